// File: rtl/calc_pkg.sv
// Shared opcode, status and FSM state definitions for the calculator execution engine.
package calc_pkg;

  localparam logic [3:0] OP_CODE_ADD = 4'd0;
  localparam logic [3:0] OP_CODE_SUB = 4'd1;
  localparam logic [3:0] OP_CODE_MUL = 4'd2;
  localparam logic [3:0] OP_CODE_DIV = 4'd3;
  localparam logic [3:0] OP_CODE_AND = 4'd4;
  localparam logic [3:0] OP_CODE_OR  = 4'd5;
  localparam logic [3:0] OP_CODE_XOR = 4'd6;

  localparam logic [1:0] STATUS_CODE_OK      = 2'b00;
  localparam logic [1:0] STATUS_CODE_DIV0    = 2'b01;
  localparam logic [1:0] STATUS_CODE_ILLEGAL = 2'b10;

  typedef enum logic [3:0] {
    OP_ADD = OP_CODE_ADD,
    OP_SUB = OP_CODE_SUB,
    OP_MUL = OP_CODE_MUL,
    OP_DIV = OP_CODE_DIV,
    OP_AND = OP_CODE_AND,
    OP_OR  = OP_CODE_OR,
    OP_XOR = OP_CODE_XOR
  } calc_op_e;

  typedef enum logic [1:0] {
    STATUS_OK      = STATUS_CODE_OK,
    STATUS_DIV0    = STATUS_CODE_DIV0,
    STATUS_ILLEGAL = STATUS_CODE_ILLEGAL
  } calc_status_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } calc_state_e;

endpackage

// File: rtl/calc_iter_unit.sv
// Iterative MUL (shift-add) / DIV (restoring) datapath sharing one hi/lo shift register.
// Divider path is present only when CALC_DIV_EN is defined.
module calc_iter_unit
  import calc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] lo,
  output logic [DATA_WIDTH-1:0] hi
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  logic                  active_q, active_d;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] opd_q, opd_d;
  logic [DATA_WIDTH:0]   mul_sum;

`ifdef CALC_DIV_EN
  logic                  div_q, div_d;
  logic [DATA_WIDTH:0]   div_shift;
  logic [DATA_WIDTH:0]   div_trial;
`else
  logic [3:0]            unused_op;
  assign unused_op = op;
`endif

  // lo holds the multiplier (MUL) or dividend/quotient (DIV); opd holds the other operand
  always_comb begin
    active_d = active_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    opd_d    = opd_q;
    mul_sum  = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opd_q}) : {1'b0, hi_q};
`ifdef CALC_DIV_EN
    div_d     = div_q;
    div_shift = {hi_q, lo_q[DATA_WIDTH-1]};
    div_trial = div_shift - {1'b0, opd_q};
`endif
    if (start) begin
      active_d = 1'b1;
      cnt_d    = CNT_W'(DATA_WIDTH - 1);
      hi_d     = '0;
`ifdef CALC_DIV_EN
      div_d    = (op == OP_DIV);
      lo_d     = (op == OP_DIV) ? a : b;
      opd_d    = (op == OP_DIV) ? b : a;
`else
      lo_d     = b;
      opd_d    = a;
`endif
    end else if (active_q) begin
`ifdef CALC_DIV_EN
      if (div_q) begin
        hi_d = div_trial[DATA_WIDTH] ? div_shift[DATA_WIDTH-1:0] : div_trial[DATA_WIDTH-1:0];
        lo_d = {lo_q[DATA_WIDTH-2:0], ~div_trial[DATA_WIDTH]};
      end else begin
        hi_d = mul_sum[DATA_WIDTH:1];
        lo_d = {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
      end
`else
      hi_d = mul_sum[DATA_WIDTH:1];
      lo_d = {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
`endif
      if (cnt_q == '0) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      opd_q    <= '0;
`ifdef CALC_DIV_EN
      div_q    <= 1'b0;
`endif
    end else begin
      active_q <= active_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      opd_q    <= opd_d;
`ifdef CALC_DIV_EN
      div_q    <= div_d;
`endif
    end
  end

  assign done = done_q;
  assign lo   = lo_q;
  assign hi   = hi_q;

endmodule

// File: rtl/calc_exec_unit.sv
// Calculator execution engine: command/result handshakes, FSM and single-cycle ALU.
// Define CALC_DIV_EN to build the divider; otherwise opcode 3 reports illegal.
module calc_exec_unit
  import calc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [DATA_WIDTH-1:0] res_hi,
  output logic [1:0]            res_status,
  output logic                  busy
);

  calc_state_e           state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic [DATA_WIDTH-1:0] res_hi_q, res_hi_d;
  calc_status_e          res_status_q, res_status_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  busy_q, busy_d;

  logic                  exec_c;
  logic                  iter_start;
  logic                  iter_done;
  logic [DATA_WIDTH-1:0] iter_lo, iter_hi;
  logic [DATA_WIDTH-1:0] alu_data, alu_hi;
  calc_status_e          alu_status;
  logic [DATA_WIDTH:0]   add_sum, sub_diff;

  // Commands that need the iterative datapath
  always_comb begin
    exec_c = (cmd_op == OP_CODE_MUL);
`ifdef CALC_DIV_EN
    if ((cmd_op == OP_CODE_DIV) && (cmd_b != '0)) exec_c = 1'b1;
`endif
  end

  // Single-cycle ALU on the latched command; DIV only reaches here with b == 0
  always_comb begin
    alu_data   = '0;
    alu_hi     = '0;
    alu_status = STATUS_OK;
    add_sum    = {1'b0, a_q} + {1'b0, b_q};
    sub_diff   = {1'b0, a_q} - {1'b0, b_q};
    case (op_q)
      OP_ADD: begin
        alu_data = add_sum[DATA_WIDTH-1:0];
        alu_hi   = DATA_WIDTH'(add_sum[DATA_WIDTH]);
      end
      OP_SUB: begin
        alu_data = sub_diff[DATA_WIDTH-1:0];
        alu_hi   = DATA_WIDTH'(sub_diff[DATA_WIDTH]);
      end
      OP_AND: alu_data = a_q & b_q;
      OP_OR:  alu_data = a_q | b_q;
      OP_XOR: alu_data = a_q ^ b_q;
`ifdef CALC_DIV_EN
      OP_DIV: begin
        alu_data   = '1;
        alu_hi     = a_q;
        alu_status = STATUS_DIV0;
      end
`endif
      default: alu_status = STATUS_ILLEGAL;
    endcase
  end

  // DONE spends its first cycle capturing the ALU result, then waits for res_ready
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_hi_d     = res_hi_q;
    res_status_d = res_status_q;
    iter_start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d = cmd_op;
          a_d  = cmd_a;
          b_d  = cmd_b;
          if (exec_c) begin
            iter_start = 1'b1;
            state_d    = S_EXEC;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_EXEC: begin
        if (iter_done) begin
          res_data_d   = iter_lo;
          res_hi_d     = iter_hi;
          res_status_d = STATUS_OK;
          res_valid_d  = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        if (!res_valid_q) begin
          res_data_d   = alu_data;
          res_hi_d     = alu_hi;
          res_status_d = alu_status;
          res_valid_d  = 1'b1;
        end else if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_hi_q     <= '0;
      res_status_q <= STATUS_OK;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_hi_q     <= res_hi_d;
      res_status_q <= res_status_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
    end
  end

  calc_iter_unit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_iter (
    .clk  (ACLK),
    .rst  (ARESET),
    .start(iter_start),
    .op   (cmd_op),
    .a    (cmd_a),
    .b    (cmd_b),
    .done (iter_done),
    .lo   (iter_lo),
    .hi   (iter_hi)
  );

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_hi     = res_hi_q;
  assign res_status = res_status_q;

endmodule

// File: tb/tb_calc_exec_unit.sv
// Directed-vector bench for calc_exec_unit, plus an in-order random stream against a reference model.
module tb_calc_exec_unit;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data, res_hi;
  logic [1:0]  res_status;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 ACLK = ~ACLK;

  calc_exec_unit #(.DATA_WIDTH(32)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_hi    (res_hi),
    .res_status(res_status),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [65:0] act, input logic [65:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // {status, hi, data} expected for one command
  function automatic logic [65:0] ref_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] w;
    case (op)
      4'd0: begin
        w = {32'd0, a} + {32'd0, b};
        return {2'b00, 31'd0, w[32], w[31:0]};
      end
      4'd1: return {2'b00, 31'd0, 1'(a < b), a - b};
      4'd2: begin
        w = 64'(a) * 64'(b);
        return {2'b00, w};
      end
`ifdef CALC_DIV_EN
      4'd3: begin
        if (b == 32'd0) return {2'b01, a, 32'hFFFF_FFFF};
        return {2'b00, a % b, a / b};
      end
`endif
      4'd4: return {2'b00, 32'd0, a & b};
      4'd5: return {2'b00, 32'd0, a | b};
      4'd6: return {2'b00, 32'd0, a ^ b};
      default: return {2'b10, 64'd0};
    endcase
  endfunction

  // Called at a negedge; returns edges from accept to res_valid and the outputs seen then
  task automatic run_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [65:0] got);
    int g;
    g = 0;
    while (!cmd_ready && g < 100) begin
      @(negedge ACLK);
      g++;
    end
    if (!cmd_ready) check_eq("cmd_ready_timeout", 66'(cmd_ready), 66'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    @(negedge ACLK);
    cmd_valid = 1'b0;
    cmd_op    = 4'($urandom);
    cmd_a     = $urandom;
    cmd_b     = $urandom;
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(negedge ACLK);
      lat++;
    end
    got = {res_status, res_hi, res_data};
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(negedge ACLK);
    res_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          highs;
    logic [65:0] got;
    logic [65:0] hold;
    int          issued, done_cnt, outstanding, cyc;
    logic        accepted;
    logic [65:0] expq[$];

    ARESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 4'd0;
    cmd_a     = 32'd0;
    cmd_b     = 32'd0;
    res_ready = 1'b0;
    repeat (3) @(negedge ACLK);
    check_eq("reset_ctrl", 66'({cmd_ready, res_valid, busy}), 66'b100);
    check_eq("reset_res", {res_status, res_hi, res_data}, 66'd0);
    ARESET = 1'b0;
    @(negedge ACLK);

    run_cmd(4'd0, 32'hFFFF_FFFF, 32'h0000_0002, lat, got);
    check_eq("add_carry_lat", 66'(lat), 66'd1);
    check_eq("add_carry_res", got, {2'b00, 32'd1, 32'd1});
    check_eq("add_busy_ready", 66'({busy, cmd_ready}), 66'b10);
    ack();
    check_eq("add_after_ack", 66'({cmd_ready, res_valid, busy}), 66'b100);

    run_cmd(4'd2, 32'h0001_0000, 32'h0003_0000, lat, got);
    check_eq("mul_lat", 66'(lat), 66'd33);
    check_eq("mul_res", got, {2'b00, 32'h0000_0003, 32'h0000_0000});
    ack();

    run_cmd(4'd3, 32'd100, 32'd7, lat, got);
`ifdef CALC_DIV_EN
    check_eq("div_lat", 66'(lat), 66'd33);
    check_eq("div_res", got, {2'b00, 32'd2, 32'd14});
`else
    check_eq("div_lat", 66'(lat), 66'd1);
    check_eq("div_res", got, {2'b10, 64'd0});
`endif
    ack();

    run_cmd(4'd3, 32'd5, 32'd0, lat, got);
    check_eq("div0_lat", 66'(lat), 66'd1);
`ifdef CALC_DIV_EN
    check_eq("div0_res", got, {2'b01, 32'd5, 32'hFFFF_FFFF});
`else
    check_eq("div0_res", got, {2'b10, 64'd0});
`endif
    ack();

    run_cmd(4'd9, 32'h1234_5678, 32'h9ABC_DEF0, lat, got);
    check_eq("illegal_lat", 66'(lat), 66'd1);
    check_eq("illegal_res", got, {2'b10, 64'd0});
    hold = got;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      check_eq("stall_ctrl", 66'({res_valid, cmd_ready, busy}), 66'b101);
      check_eq("stall_res", {res_status, res_hi, res_data}, hold);
    end
    ack();
    check_eq("stall_release", 66'({cmd_ready, res_valid, busy}), 66'b100);

    run_cmd(4'd1, 32'd3, 32'd5, lat, got);
    check_eq("sub_borrow", got, {2'b00, 32'd1, 32'hFFFF_FFFE});
    ack();
    run_cmd(4'd1, 32'd5, 32'd3, lat, got);
    check_eq("sub_noborrow", got, {2'b00, 32'd0, 32'd2});
    ack();
    run_cmd(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, got);
    check_eq("mul_max", got, {2'b00, 32'hFFFF_FFFE, 32'h0000_0001});
    ack();

    // res_ready held high before the result exists
    res_ready = 1'b1;
    run_cmd(4'd5, 32'hA000_0001, 32'h0500_0010, lat, got);
    check_eq("or_early_ready_lat", 66'(lat), 66'd1);
    check_eq("or_early_ready_res", got, {2'b00, 32'd0, 32'hA500_0011});
    @(negedge ACLK);
    res_ready = 1'b0;
    check_eq("or_early_ready_done", 66'({cmd_ready, res_valid}), 66'b10);

    // Abort a MUL ten cycles in
    cmd_valid = 1'b1;
    cmd_op    = 4'd2;
    cmd_a     = 32'd1234;
    cmd_b     = 32'd5678;
    @(negedge ACLK);
    cmd_valid = 1'b0;
    repeat (9) @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    check_eq("abort_ctrl", 66'({cmd_ready, res_valid, busy}), 66'b100);
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge ACLK);
      if (res_valid || busy) highs++;
    end
    check_eq("abort_no_result", 66'(highs), 66'd0);

    // Command presented under reset is dropped
    ARESET    = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 4'd0;
    cmd_a     = 32'd1;
    cmd_b     = 32'd1;
    @(negedge ACLK);
    ARESET    = 1'b0;
    cmd_valid = 1'b0;
    repeat (3) @(negedge ACLK);
    check_eq("reset_cmd_ignored", 66'({cmd_ready, res_valid, busy}), 66'b100);

    run_cmd(4'd6, 32'hF0F0_F0F0, 32'hFFFF_0000, lat, got);
    check_eq("xor_lat", 66'(lat), 66'd1);
    check_eq("xor_res", got, {2'b00, 32'd0, 32'h0F0F_F0F0});
    ack();

    // Random stream: handshakes predicted at each negedge for the following posedge
    issued      = 0;
    done_cnt    = 0;
    outstanding = 0;
    cyc         = 0;
    accepted    = 1'b0;
    while (done_cnt < 200 && cyc < 30000) begin
      @(negedge ACLK);
      cyc++;
      if (accepted) cmd_valid = 1'b0;
      accepted = 1'b0;
      if (!cmd_valid && issued < 200 && $urandom_range(0, 3) != 0) begin
        cmd_op    = 4'($urandom_range(0, 9));
        cmd_a     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
        cmd_b     = ($urandom_range(0, 5) == 0) ? 32'd0 :
                    ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 40)) : $urandom;
        cmd_valid = 1'b1;
      end
      res_ready = ($urandom_range(0, 2) != 0);
      if (cmd_valid && cmd_ready) begin
        check_eq("rnd_accept_while_pending", 66'(outstanding), 66'd0);
        expq.push_back(ref_model(cmd_op, cmd_a, cmd_b));
        outstanding++;
        issued++;
        accepted = 1'b1;
      end
      if (res_valid && res_ready) begin
        if (expq.size() == 0) check_eq("rnd_unexpected_result", 66'd1, 66'd0);
        else check_eq("rnd_result", {res_status, res_hi, res_data}, expq.pop_front());
        outstanding--;
        done_cnt++;
      end
    end
    @(negedge ACLK);
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    check_eq("rnd_result_count", 66'(done_cnt), 66'd200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
